// File: rtl/disp_share_ctrl_if.sv
// Write-request bus between the two digit producers and the display controller.
// A requester holds req with idx/data until it sees its one-cycle gnt pulse.
interface disp_share_ctrl_if #(
  parameter int DW = 4
);
  logic [1:0]    req;
  logic [1:0]    idx0;
  logic [1:0]    idx1;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic [1:0]    gnt;

  modport master (output req, idx0, idx1, data0, data1, input gnt);
  modport slave  (input req, idx0, idx1, data0, data1, output gnt);
endinterface

// File: rtl/disp_share_ctrl.sv
// 4-digit seven-segment controller: round-robin shared digit register file plus prescaled scan.
// Define SCAN_BLANK_EN to insert an all-off blank phase before each digit is driven.
module disp_share_ctrl #(
  parameter int DW    = 4,
  parameter int PRE_W = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  disp_share_ctrl_if.slave    bus,
  input  logic [1:0]          speed_sel,
  input  logic                speed_stb,
  output logic [3:0]          grounds,
  output logic [1:0]          scan_idx,
  output logic [DW-1:0]       digit_val
);

  logic [3:0][DW-1:0] digit_q, digit_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               last_q, last_d;
  logic [1:0]         elig;
  logic               wr_sel;

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [1:0]         speed_q, speed_d;
  logic               tap, tap_d_q, tick;
  logic [1:0]         scan_idx_q, scan_idx_d;
  logic [3:0]         grounds_q, grounds_d;
`ifdef SCAN_BLANK_EN
  logic               blank_q, blank_d;
`endif

  // A requester that was granted last cycle is masked so its held req cannot write twice.
  always_comb begin
    elig    = bus.req & ~gnt_q;
    wr_sel  = 1'b0;
    case (elig)
      2'b10:   wr_sel = 1'b1;
      2'b11:   wr_sel = ~last_q;
      default: wr_sel = 1'b0;
    endcase
    gnt_d   = '0;
    last_d  = last_q;
    digit_d = digit_q;
    if (|elig) begin
      gnt_d[wr_sel] = 1'b1;
      last_d        = wr_sel;
      if (wr_sel) digit_d[bus.idx1] = bus.data1;
      else        digit_d[bus.idx0] = bus.data0;
    end
  end

  always_comb begin
    case (speed_q)
      2'd1:    tap = pre_q[19];
      2'd2:    tap = pre_q[25];
      default: tap = pre_q[15];
    endcase
    tick       = tap & ~tap_d_q;
    pre_d      = pre_q + PRE_W'(1);
    speed_d    = speed_stb ? speed_sel : speed_q;
    scan_idx_d = scan_idx_q;
    grounds_d  = grounds_q;
`ifdef SCAN_BLANK_EN
    // The index moves on entry to blank so the drive phase already shows the next digit.
    blank_d = blank_q;
    if (tick) begin
      blank_d = ~blank_q;
      if (!blank_q) begin
        scan_idx_d = scan_idx_q + 2'd1;
        grounds_d  = 4'b1111;
      end else begin
        grounds_d  = ~(4'b0001 << scan_idx_q);
      end
    end
`else
    if (tick) begin
      scan_idx_d = scan_idx_q + 2'd1;
      grounds_d  = {grounds_q[2:0], grounds_q[3]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q    <= '0;
      gnt_q      <= '0;
      last_q     <= 1'b1;
      pre_q      <= '0;
      speed_q    <= '0;
      tap_d_q    <= 1'b0;
      scan_idx_q <= '0;
      grounds_q  <= 4'b1110;
`ifdef SCAN_BLANK_EN
      blank_q    <= 1'b0;
`endif
    end else begin
      digit_q    <= digit_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      pre_q      <= pre_d;
      speed_q    <= speed_d;
      tap_d_q    <= tap;
      scan_idx_q <= scan_idx_d;
      grounds_q  <= grounds_d;
`ifdef SCAN_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign bus.gnt   = gnt_q;
  assign grounds   = grounds_q;
  assign scan_idx  = scan_idx_q;
  assign digit_val = digit_q[scan_idx_q];

endmodule

// File: tb/tb_disp_share_ctrl.sv
// Randomized bench for disp_share_ctrl against a cycle-count/tick-count reference model.
module tb_disp_share_ctrl;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    speed_sel = 2'd0;
  logic          speed_stb = 1'b0;
  logic [3:0]    grounds;
  logic [1:0]    scan_idx;
  logic [DW-1:0] digit_val;

  disp_share_ctrl_if #(.DW(DW)) bus ();

  disp_share_ctrl #(.DW(DW), .PRE_W(26)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .speed_sel (speed_sel),
    .speed_stb (speed_stb),
    .grounds   (grounds),
    .scan_idx  (scan_idx),
    .digit_val (digit_val)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time since reset, number of scan ticks, digit contents.
  int unsigned   pre_m;
  bit            tapd_m;
  int            speed_m;
  int            ticks_m;
  logic [DW-1:0] dig_m [4];
  logic [1:0]    gnt_m;
  int            last_m;

  function automatic int tap_of(int s);
    case (s)
      1:       return 19;
      2:       return 25;
      default: return 15;
    endcase
  endfunction

  function automatic logic [1:0] idx_for(int n);
`ifdef SCAN_BLANK_EN
    return 2'(((n + 1) / 2) % 4);
`else
    return 2'(n % 4);
`endif
  endfunction

  function automatic logic [3:0] grounds_for(int n);
    logic [1:0] i;
    i = idx_for(n);
`ifdef SCAN_BLANK_EN
    if (n % 2 == 1) return 4'hF;
`endif
    return ~(4'b0001 << i);
  endfunction

  task automatic model_reset();
    pre_m = 0; tapd_m = 0; speed_m = 0; ticks_m = 0;
    gnt_m = 2'b00; last_m = 1;
    for (int i = 0; i < 4; i++) dig_m[i] = '0;
  endtask

  task automatic model_step();
    logic [1:0] elig;
    int w;
    bit t;
    elig = bus.req & ~gnt_m;
    w = -1;
    if (elig == 2'b01) w = 0;
    else if (elig == 2'b10) w = 1;
    else if (elig == 2'b11) w = (last_m == 1) ? 0 : 1;
    gnt_m = 2'b00;
    if (w == 0) dig_m[bus.idx0] = bus.data0;
    if (w == 1) dig_m[bus.idx1] = bus.data1;
    if (w >= 0) begin
      gnt_m[w] = 1'b1;
      last_m   = w;
    end
    t = ((pre_m >> tap_of(speed_m)) & 1) != 0;
    if (t && !tapd_m) ticks_m++;
    tapd_m = t;
    pre_m  = (pre_m + 1) & 32'h03FF_FFFF;
    if (speed_stb) speed_m = int'(speed_sel);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("gnt", {30'd0, bus.gnt}, {30'd0, gnt_m});
    chk("scan_idx", {30'd0, scan_idx}, {30'd0, idx_for(ticks_m)});
    chk("grounds", {28'd0, grounds}, {28'd0, grounds_for(ticks_m)});
    chk("digit_val", {28'd0, digit_val}, {28'd0, dig_m[idx_for(ticks_m)]});
  end

  int edge_cnt = 0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) edge_cnt = 0;
    else        edge_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic drive_random();
    for (int r = 0; r < 2; r++) begin
      if (bus.gnt[r] || !bus.req[r]) begin
        bus.req[r] = 1'($urandom_range(0, 1));
        if (r == 0) begin
          bus.idx0  = 2'($urandom_range(0, 3));
          bus.data0 = DW'($urandom);
        end else begin
          bus.idx1  = 2'($urandom_range(0, 3));
          bus.data1 = DW'($urandom);
        end
      end
    end
    speed_sel = 2'($urandom_range(0, 3));
  endtask

  task automatic run_random(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive_random();
    end
  endtask

  task automatic strobe_speed(input logic [1:0] sel);
    speed_sel = sel;
    speed_stb = 1'b1;
    @(posedge clk); #1;
    speed_stb = 1'b0;
    speed_sel = 2'($urandom_range(0, 3));
  endtask

  logic [1:0] seq [4];
  int commits;

  initial begin
    bus.req = 2'b00; bus.idx0 = '0; bus.idx1 = '0; bus.data0 = '0; bus.data1 = '0;
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", {30'd0, bus.gnt}, 32'd0);
    chk("reset_grounds", {28'd0, grounds}, 32'hE);
    chk("reset_scan_idx", {30'd0, scan_idx}, 32'd0);
    chk("reset_digit_val", {28'd0, digit_val}, 32'd0);
    rst_n = 1'b1;

    // Both requesters held continuously: strict alternation starting with requester 0.
    bus.req = 2'b11; bus.idx0 = 2'd0; bus.data0 = 4'h5; bus.idx1 = 2'd1; bus.data1 = 4'h7;
    commits = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("contend_gnt", {30'd0, bus.gnt}, {30'd0, seq[i]});
      if (bus.gnt != 2'b00) commits++;
    end
    chk("contend_commits", commits, 32'd4);
    bus.req = 2'b00;
    @(posedge clk); #1;

    bus.req = 2'b01; bus.idx0 = 2'd2; bus.data0 = 4'hA;
    @(posedge clk); #1;
    chk("single_gnt", {30'd0, bus.gnt}, 32'd1);
    @(posedge clk); #1;
    chk("single_held_ignored", {30'd0, bus.gnt}, 32'd0);
    bus.req = 2'b00;

    while (scan_idx == 2'd0 && edge_cnt < 40000) begin
      @(posedge clk); #1;
      if (scan_idx == 2'd0) drive_random();
    end
    chk("first_tick_cycle", edge_cnt - 1, 32'd32768);
    chk("first_tick_idx", {30'd0, scan_idx}, {30'd0, idx_for(1)});
    chk("first_tick_grounds", {28'd0, grounds}, {28'd0, grounds_for(1)});

    // Toggling between a low and a high tap while pre[15]=1 forces one tick per toggle.
    strobe_speed(2'd1);
    run_random(50);
    chk("slow_tap_no_tick", {30'd0, scan_idx}, {30'd0, idx_for(1)});
    strobe_speed(2'd3);
    run_random(1);
    chk("switch_tick_a", {30'd0, scan_idx}, {30'd0, idx_for(2)});
    run_random(50);
    strobe_speed(2'd2);
    run_random(1000);
    chk("tap25_no_tick", {30'd0, scan_idx}, {30'd0, idx_for(2)});
    strobe_speed(2'd0);
    run_random(1);
    chk("switch_tick_b", {30'd0, scan_idx}, {30'd0, idx_for(3)});
    run_random(50);
    strobe_speed(2'd1);
    run_random(10);
    strobe_speed(2'd0);
    run_random(1);
    chk("frame_wrap_idx", {30'd0, scan_idx}, {30'd0, idx_for(4)});
    chk("frame_wrap_grounds", {28'd0, grounds}, {28'd0, grounds_for(4)});
    run_random(200);

    // Reset lands in the same cycle a write request is presented.
    bus.req = 2'b01; bus.idx0 = 2'd0; bus.data0 = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt_async", {30'd0, bus.gnt}, 32'd0);
    @(posedge clk); #1;
    chk("rst_gnt", {30'd0, bus.gnt}, 32'd0);
    chk("rst_digit0", {28'd0, digit_val}, 32'd0);
    chk("rst_scan_idx", {30'd0, scan_idx}, 32'd0);
    chk("rst_grounds", {28'd0, grounds}, 32'hE);
    bus.req = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_gnt", {30'd0, bus.gnt}, 32'd0);
    chk("post_rst_digit0", {28'd0, digit_val}, 32'd0);
    run_random(300);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
